// File: rtl/medidor_ciclo_trabalho.sv
// PWM duty-cycle meter: measures period and high time between synced rising edges,
// divides serially to a 0..99 percent value and drives two active-low 7-segment digits.
module medidor_ciclo_trabalho #(
    parameter int unsigned LARGURA = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sinal_pwm,
    output logic [6:0] duty,
    output logic       valido,
    output logic [6:0] display_msb,
    output logic [6:0] display_lsb
);

    localparam int unsigned NDIV = LARGURA + 7;
    localparam int unsigned WIDX = $clog2(NDIV);
    localparam logic [LARGURA-1:0] CNT_MAX = '1;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    typedef enum logic [1:0] {ARMAR, MEDIR, DIVIDIR, ATUALIZAR} estado_t;

    estado_t            estado_q, estado_d;
    logic               sync1_q, sync2_q, prev_q;
    logic [LARGURA-1:0] cnt_periodo_q, cnt_periodo_d;
    logic [LARGURA-1:0] cnt_alto_q, cnt_alto_d;
    logic [LARGURA-1:0] periodo_q, periodo_d;
    logic [LARGURA-1:0] alto_q, alto_d;
    logic [LARGURA-1:0] resto_q, resto_d;
    logic [NDIV-1:0]    quoc_q, quoc_d;
    logic [WIDX-1:0]    idx_q, idx_d;
    logic [6:0]         duty_q, duty_d;
    logic               valido_q, valido_d;
    logic [6:0]         msb_q, msb_d;
    logic [6:0]         lsb_q, lsb_d;

    logic               borda;
    logic               timeout;
    logic [NDIV-1:0]    dividendo;
    logic [WIDX-1:0]    pos;
    logic [LARGURA:0]   tentativa;
    logic               cabe;
    logic [6:0]         saturado;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign borda     = sync2_q & ~prev_q;
    assign timeout   = ((estado_q == ARMAR) || (estado_q == MEDIR)) && (cnt_periodo_q == CNT_MAX);
    assign dividendo = NDIV'(alto_q) * NDIV'(100);
    // dividend bits are consumed MSB first, one per DIVIDIR cycle
    assign pos       = WIDX'(NDIV - 1) - idx_q;
    assign tentativa = {resto_q, dividendo[pos]};
    assign cabe      = tentativa >= {1'b0, periodo_q};
    assign saturado  = (quoc_q > NDIV'(99)) ? 7'd99 : quoc_q[6:0];

    always_comb begin
        estado_d      = estado_q;
        cnt_periodo_d = cnt_periodo_q;
        cnt_alto_d    = cnt_alto_q;
        periodo_d     = periodo_q;
        alto_d        = alto_q;
        resto_d       = resto_q;
        quoc_d        = quoc_q;
        idx_d         = idx_q;
        duty_d        = duty_q;
        valido_d      = valido_q;
        msb_d         = msb_q;
        lsb_d         = lsb_q;

        if (borda) begin
            cnt_periodo_d = LARGURA'(1);
            cnt_alto_d    = LARGURA'(1);
        end else begin
            if (cnt_periodo_q != CNT_MAX) cnt_periodo_d = cnt_periodo_q + 1'b1;
            if (sync2_q && (cnt_alto_q != CNT_MAX)) cnt_alto_d = cnt_alto_q + 1'b1;
        end

        if (timeout) begin
            // counters restart from zero so the next timeout needs a full window again
            cnt_periodo_d = '0;
            cnt_alto_d    = '0;
            duty_d        = sync2_q ? 7'd99 : 7'd0;
            msb_d         = sync2_q ? seg7(4'd9) : SEG_ZERO;
            lsb_d         = sync2_q ? seg7(4'd9) : SEG_ZERO;
            valido_d      = 1'b1;
            estado_d      = ARMAR;
        end else begin
            case (estado_q)
                ARMAR: begin
                    if (borda) estado_d = MEDIR;
                end
                MEDIR: begin
                    if (borda) begin
                        periodo_d = cnt_periodo_q;
                        alto_d    = cnt_alto_q;
                        resto_d   = '0;
                        quoc_d    = '0;
                        idx_d     = '0;
                        estado_d  = DIVIDIR;
                    end
                end
                DIVIDIR: begin
                    resto_d = cabe ? LARGURA'(tentativa - {1'b0, periodo_q}) : tentativa[LARGURA-1:0];
                    quoc_d  = {quoc_q[NDIV-2:0], cabe};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == WIDX'(NDIV - 1)) estado_d = ATUALIZAR;
                end
                ATUALIZAR: begin
                    duty_d   = saturado;
                    msb_d    = seg7(4'(saturado / 7'd10));
                    lsb_d    = seg7(4'(saturado % 7'd10));
                    valido_d = 1'b1;
                    estado_d = MEDIR;
                end
                default: estado_d = ARMAR;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q      <= ARMAR;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            cnt_periodo_q <= '0;
            cnt_alto_q    <= '0;
            periodo_q     <= '0;
            alto_q        <= '0;
            resto_q       <= '0;
            quoc_q        <= '0;
            idx_q         <= '0;
            duty_q        <= '0;
            valido_q      <= 1'b0;
            msb_q         <= SEG_ZERO;
            lsb_q         <= SEG_ZERO;
        end else begin
            estado_q      <= estado_d;
            sync1_q       <= sinal_pwm;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            cnt_periodo_q <= cnt_periodo_d;
            cnt_alto_q    <= cnt_alto_d;
            periodo_q     <= periodo_d;
            alto_q        <= alto_d;
            resto_q       <= resto_d;
            quoc_q        <= quoc_d;
            idx_q         <= idx_d;
            duty_q        <= duty_d;
            valido_q      <= valido_d;
            msb_q         <= msb_d;
            lsb_q         <= lsb_d;
        end
    end

    assign duty        = duty_q;
    assign valido      = valido_q;
    assign display_msb = msb_q;
    assign display_lsb = lsb_q;

endmodule

// File: tb/tb_medidor_ciclo_trabalho.sv
// Bench for medidor_ciclo_trabalho: time-level model of edges, periods and timeouts
// checked every cycle, plus literal expectations at the end of each directed phase.
module tb_medidor_ciclo_trabalho;

    localparam int L    = 10;
    localparam int N    = L + 7;
    localparam int CMAX = (1 << L) - 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sinal_pwm = 1'b0;
    logic [6:0] duty;
    logic       valido;
    logic [6:0] display_msb;
    logic [6:0] display_lsb;

    int n_chk  = 0;
    int n_fail = 0;

    medidor_ciclo_trabalho #(.LARGURA(L)) dut (
        .clock       (clock),
        .reset       (reset),
        .sinal_pwm   (sinal_pwm),
        .duty        (duty),
        .valido      (valido),
        .display_msb (display_msb),
        .display_lsb (display_lsb)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'b1000000;
            1: seg = 7'b1111001;
            2: seg = 7'b0100100;
            3: seg = 7'b0110000;
            4: seg = 7'b0011001;
            5: seg = 7'b0010010;
            6: seg = 7'b0000010;
            7: seg = 7'b1111000;
            8: seg = 7'b0000000;
            9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    // model: mode 0 = waiting for first edge, 1 = measuring, 2 = busy dividing
    bit hist [0:16383];
    int cyc = 0;
    int origin = 0;
    int busy_end = 0;
    int pend_val = 0;
    int mode = 0;
    bit ms1 = 0, ms2 = 0, ms2p = 0;
    int exp_duty = 0;
    bit exp_val = 0;
    bit started = 0;

    always @(posedge clock) begin
        int c, p, a, q;
        bit ed;
        c = cyc;
        if (reset) begin
            ms1 = 0; ms2 = 0; ms2p = 0;
            mode = 0; origin = c + 1;
            exp_duty = 0; exp_val = 0;
        end else begin
            hist[c] = ms2;
            ed = ms2 && !ms2p;
            if (mode != 2 && (c - origin) == CMAX) begin
                exp_duty = ms2 ? 99 : 0;
                exp_val  = 1;
                mode     = 0;
                origin   = c + 1;
            end else if (ed) begin
                if (mode == 0) begin
                    mode = 1; origin = c;
                end else if (mode == 1) begin
                    p = c - origin;
                    a = 0;
                    for (int i = origin; i < c; i++) a += int'(hist[i]);
                    q = (a * 100) / p;
                    if (q > 99) q = 99;
                    pend_val = q;
                    mode     = 2;
                    busy_end = c + N + 1;
                    origin   = c;
                end else begin
                    origin = c;
                end
            end
            if (mode == 2 && c == busy_end) begin
                mode     = 1;
                exp_duty = pend_val;
                exp_val  = 1;
            end
            ms2p = ms2; ms2 = ms1; ms1 = sinal_pwm;
        end
        started = 1;
        cyc = cyc + 1;
    end

    always @(negedge clock) begin
        if (started) begin
            n_chk = n_chk + 1;
            if (duty !== 7'(exp_duty) || valido !== exp_val ||
                display_msb !== seg(exp_duty / 10) || display_lsb !== seg(exp_duty % 10)) begin
                n_fail = n_fail + 1;
                $display("FAIL cycle_cmp t=%0t duty=%0d want %0d valido=%0b want %0b msb=%b want %b lsb=%b want %b",
                         $time, duty, exp_duty, valido, exp_val, display_msb, seg(exp_duty / 10),
                         display_lsb, seg(exp_duty % 10));
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_chk = n_chk + 1;
        if (got != want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic pwm(input int period, input int high, input int n);
        for (int k = 0; k < n; k++) begin
            sinal_pwm = 1'b1;
            repeat (high) @(negedge clock);
            sinal_pwm = 1'b0;
            repeat (period - high) @(negedge clock);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_duty", int'(duty), 0);
        chk("reset_valido", int'(valido), 0);
        chk("reset_msb", int'(display_msb), 7'b1000000);
        chk("reset_lsb", int'(display_lsb), 7'b1000000);
        repeat (5) @(negedge clock);

        pwm(100, 25, 4);
        chk("p100_duty", int'(duty), 25);
        chk("p100_model", exp_duty, 25);
        chk("p100_msb", int'(display_msb), 7'b0100100);
        chk("p100_lsb", int'(display_lsb), 7'b0010010);
        chk("p100_valido", int'(valido), 1);

        pwm(3, 1, 30);
        chk("p3_duty", int'(duty), 33);
        pwm(2, 1, 30);
        chk("p2_duty", int'(duty), 50);
        chk("p2_model", exp_duty, 50);

        sinal_pwm = 1'b1;
        repeat (1100) @(negedge clock);
        chk("hold1_duty", int'(duty), 99);
        chk("hold1_msb", int'(display_msb), 7'b0010000);
        chk("hold1_lsb", int'(display_lsb), 7'b0010000);
        sinal_pwm = 1'b0;
        repeat (1100) @(negedge clock);
        chk("hold0_duty", int'(duty), 0);
        chk("hold0_msb", int'(display_msb), 7'b1000000);
        chk("hold0_valido", int'(valido), 1);

        pwm(50, 20, 2);
        sinal_pwm = 1'b1;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sinal_pwm = 1'b0;
        chk("rst_div_duty", int'(duty), 0);
        chk("rst_div_valido", int'(valido), 0);
        chk("rst_div_msb", int'(display_msb), 7'b1000000);
        repeat (4) @(negedge clock);
        pwm(50, 20, 1);
        chk("rst_one_edge_valido", int'(valido), 0);
        pwm(50, 20, 2);
        chk("rst_after_duty", int'(duty), 40);

        pwm(10, 9, 12);
        chk("p10_duty", int'(duty), 90);
        chk("p10_model", exp_duty, 90);

        pwm(200, 20, 3);
        chk("step_10", int'(duty), 10);
        pwm(200, 150, 3);
        chk("step_75", int'(duty), 75);
        chk("step_msb", int'(display_msb), 7'b1111000);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
